// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, controller state and access decode helpers
// for the data memory controller (lane mask and request error check).
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = 4'b0011 << a;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // oor: upper address bits beyond the array are non-zero
  function automatic logic is_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a,
    input logic       oor
  );
    logic bad_f3;
    logic mis;
    bad_f3 = (f3 == 3'b011)
           || (f3[2:1] == 2'b11)
           || (we && f3[2]);
    mis = (f3[1:0] == 2'b01 && a[0])
        || (f3[1:0] == 2'b10 && a != 2'b00);
    return oor | bad_f3 | mis;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: shifts the selected byte/half of a memory word to bit 0
// and sign/zero-extends per funct3. Ports: word, addr_lo, funct3 -> rdata.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] sh;

  assign sh = word >> {addr_lo, 3'b000};

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (funct3 == F3_B):
        rdata = {{(XLEN-8){sh[7]}}, sh[7:0]};
      (funct3 == F3_H):
        rdata = {{(XLEN-16){sh[15]}}, sh[15:0]};
      (funct3 == F3_BU):
        rdata = {{(XLEN-8){1'b0}}, sh[7:0]};
      (funct3 == F3_HU):
        rdata = {{(XLEN-16){1'b0}}, sh[15:0]};
      (funct3 == F3_W):
        rdata = word;
      default:
        rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte/half/word data memory, self-clearing after reset, 1-cycle
// response. Ports: req_* in, rsp_* out, init_done. DMEM_PARITY_EN adds inj_par_err.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
`ifdef DMEM_PARITY_EN
  input  logic            inj_par_err,
`endif
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            init_done
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] mem [DEPTH];
  logic [XLEN-1:0] rd_word;

  state_t          state;
  logic [AW-1:0]   clr_ptr;

  logic            accept;
  logic [AW-1:0]   idx;
  logic            oor;
  logic            err;
  logic [3:0]      mask;
  logic [XLEN-1:0] wrep;
  logic            wr_en;

  logic            p_load;
  logic            p_err;
  logic [2:0]      p_f3;
  logic [1:0]      p_a;
  logic [3:0]      p_mask;
  logic [XLEN-1:0] al_data;
  logic            par_fault;

  assign accept = req_valid & req_ready;
  assign idx    = req_addr[AW+1:2];
  assign oor    = |req_addr[XLEN-1:AW+2];
  assign err    = is_err(req_we, req_funct3,
                         req_addr[1:0], oor);
  assign mask   = lane_mask(req_funct3,
                            req_addr[1:0]);
  assign wr_en  = accept & req_we & ~err;

  always_comb begin
    wrep = req_wdata;
    case (req_funct3[1:0])
      2'b00:   wrep = {4{req_wdata[7:0]}};
      2'b01:   wrep = {2{req_wdata[15:0]}};
      default: wrep = req_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      clr_ptr   <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == AW'(DEPTH-1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      p_load    <= 1'b0;
      p_err     <= 1'b0;
      p_f3      <= '0;
      p_a       <= '0;
      p_mask    <= '0;
    end else begin
      rsp_valid <= accept;
      p_load    <= accept & ~req_we;
      p_err     <= accept & err;
      p_f3      <= req_funct3;
      p_a       <= req_addr[1:0];
      p_mask    <= mask;
    end
  end

  // Array has no reset; INIT clears it. A store is written at an
  // earlier edge than any later load reads, so RAW needs no bypass.
  always_ff @(posedge clk) begin
    if (state == INIT) begin
      mem[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (mask[l])
          mem[idx][8*l +: 8] <= wrep[8*l +: 8];
      end
    end
    if (accept)
      rd_word <= mem[idx];
  end

`ifdef DMEM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic [3:0] rd_par;
  logic [3:0] mism;

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      par[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (mask[l])
          par[idx][l] <= (^wrep[8*l +: 8])
                       ^ inj_par_err;
      end
    end
    if (accept)
      rd_par <= par[idx];
  end

  always_comb begin
    mism = '0;
    for (int l = 0; l < 4; l++)
      mism[l] = rd_par[l] ^ (^rd_word[8*l +: 8]);
  end

  assign par_fault = p_load & ~p_err
                   & |(p_mask & mism);
`else
  assign par_fault = 1'b0;
`endif

  dmem_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .word    (rd_word),
    .addr_lo (p_a),
    .funct3  (p_f3),
    .rdata   (al_data)
  );

  // Gate with rsp_valid so outputs read 0 between responses.
  assign rsp_rdata = (rsp_valid & p_load & ~p_err)
                   ? al_data : '0;
  assign rsp_err   = rsp_valid & (p_err | par_fault);

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized + directed stimulus against a byte-array model,
// scoreboard queue popped by a monitor on each rsp_valid.
module tb_dmem_ctrl;

  localparam int DEPTH = 256;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;
`ifdef DMEM_PARITY_EN
  logic        inj = 1'b0;
`endif

  dmem_ctrl #(
    .XLEN  (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
`ifdef DMEM_PARITY_EN
    .inj_par_err(inj),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic [7:0] mb  [NB];
  logic       bad [NB];
  exp_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) begin
      mb[i]  = 8'h00;
      bad[i] = 1'b0;
    end
  endtask

  function automatic int sz(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic issue(input logic        we,
                       input logic [2:0]  f3,
                       input logic [31:0] a,
                       input logic [31:0] wd,
                       input logic        inj_i);
    exp_t        e;
    int          s;
    logic        er;
    logic        pe;
    logic [31:0] v;
    s  = sz(f3);
    er = (a >= NB) || (f3 == 3'd3)
      || (f3 >= 3'd6) || (we && f3 >= 3'd4)
      || (a % s != 0);
    e.err  = er;
    e.data = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < s; i++) begin
          mb[a+i]  = wd[8*i +: 8];
          bad[a+i] = inj_i;
        end
      end else begin
        v  = '0;
        pe = 1'b0;
        for (int i = 0; i < s; i++) begin
          v  = v | (32'(mb[a+i]) << (8*i));
          pe = pe | bad[a+i];
        end
        if (f3 < 3'd4 && s < 4 && v[8*s-1])
          v = v | ~((32'd1 << (8*s)) - 1);
        e.data = v;
        e.err  = pe;
      end
    end
    q.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
`ifdef DMEM_PARITY_EN
    inj = inj_i;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
`ifdef DMEM_PARITY_EN
    inj = 1'b0;
`endif
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int edges;
    edges = 0;
    while (edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
      if (req_ready) break;
    end
    chk("init_cycles", edges, 256);
    chk("init_done", 32'(init_done), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_rdata", rsp_rdata, e.data);
        end
      end else begin
        chk("idle_zero",
            {31'(rsp_rdata != 0), rsp_err}, 0);
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        we;
    logic        ij;
    clear_model();
    #2;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_done", 32'(init_done), 0);
    #10;
    rst_n = 1'b1;
    wait_ready();
    mon_en = 1'b1;

    issue(0, 3'b010, 32'h3FC, 0, 0);
    idle(1);

    issue(1, 3'b010, 32'h10, 32'h11223344, 0);
    issue(1, 3'b000, 32'h12, 32'h000000AA, 0);
    issue(0, 3'b010, 32'h10, 0, 0);
    issue(0, 3'b000, 32'h12, 0, 0);
    issue(0, 3'b100, 32'h12, 0, 0);
    issue(0, 3'b001, 32'h12, 0, 0);
    idle(2);

    issue(1, 3'b010, 32'h20, 32'hDEADBEEF, 0);
    chk("b2b_v1", 32'(rsp_valid), 1);
    issue(0, 3'b010, 32'h20, 0, 0);
    chk("b2b_v2", 32'(rsp_valid), 1);
    idle(2);

    issue(0, 3'b010, 32'h02, 0, 0);
    issue(1, 3'b001, 32'h01, 32'hFFFF, 0);
    issue(1, 3'b010, 32'h400, 32'hCAFEF00D, 0);
    issue(0, 3'b011, 32'h10, 0, 0);
    issue(1, 3'b100, 32'h10, 32'h5A, 0);
    issue(0, 3'b010, 32'h00, 0, 0);
    issue(0, 3'b010, 32'h10, 0, 0);
    idle(2);

`ifdef DMEM_PARITY_EN
    issue(1, 3'b010, 32'h30, 32'h12345678, 1);
    issue(1, 3'b010, 32'h34, 32'h9ABCDEF0, 0);
    issue(0, 3'b100, 32'h31, 0, 0);
    issue(0, 3'b010, 32'h34, 0, 0);
    idle(2);
`endif

    repeat (600) begin
      we = 1'($urandom % 2);
      f3 = 3'($urandom % 8);
      if ($urandom % 16 == 0)
        a = $urandom_range(NB, NB + 64);
      else
        a = $urandom_range(0, 127);
      ij = 1'b0;
`ifdef DMEM_PARITY_EN
      ij = ($urandom % 4 == 0);
`endif
      issue(we, f3, a, $urandom, ij);
      if ($urandom % 4 == 0) idle(1);
    end
    idle(3);
    chk("q_drained", q.size(), 0);

    issue(1, 3'b010, 32'h40, 32'h55AA55AA, 0);
    idle(1);
    issue(0, 3'b010, 32'h40, 0, 0);
    chk("inflight_valid", 32'(rsp_valid), 1);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_valid", 32'(rsp_valid), 0);
    chk("rst_drop_ready", 32'(req_ready), 0);
    q.delete();
    clear_model();
    #9;
    rst_n = 1'b1;
    wait_ready();
    issue(0, 3'b010, 32'h40, 0, 0);
    issue(0, 3'b010, 32'h10, 0, 0);
    idle(3);
    chk("q_drained2", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
